// File: rtl/clock_pkg.sv
// Shared encodings for the clock mode controller: mode states, field selects
// and the default prescaler divide ratio.
package clock_pkg;

   typedef enum logic [1:0] {
      MODE_RUN      = 2'd0,
      MODE_SET_HOUR = 2'd1,
      MODE_SET_MIN  = 2'd2,
      MODE_SET_SEC  = 2'd3
   } mode_t;

   localparam logic [1:0] FIELD_NONE = 2'd0;
   localparam logic [1:0] FIELD_HOUR = 2'd1;
   localparam logic [1:0] FIELD_MIN  = 2'd2;
   localparam logic [1:0] FIELD_SEC  = 2'd3;

   localparam int TICK_DIV_DEFAULT = 50;

   function automatic logic [1:0] field_of(input mode_t m);
      logic [1:0] f;
      f = FIELD_NONE;
      case (m)
         MODE_RUN:      f = FIELD_NONE;
         MODE_SET_HOUR: f = FIELD_HOUR;
         MODE_SET_MIN:  f = FIELD_MIN;
         MODE_SET_SEC:  f = FIELD_SEC;
         default:       f = FIELD_NONE;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchroniser for a raw push button followed by a rising-edge
// detector; a held button gives a single one-cycle event.
module btn_edge (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic rise
);

   logic sync1_reg;
   logic sync2_reg;
   logic dly_reg;

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         dly_reg   <= 1'b0;
      end else begin
         sync1_reg <= btn;
         sync2_reg <= sync1_reg;
         dly_reg   <= sync2_reg;
      end
   end

   // Clearing dly_reg on reset lets a button held through release still fire.
   assign rise = sync2_reg & ~dly_reg;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode controller for a settable clock: cycles RUN/SET_HOUR/SET_MIN/SET_SEC,
// generates the one-second tick in RUN and digit increment pulses in SET.
import clock_pkg::*;

module clock_mode_ctrl #(
   parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       setbutton,
   input  logic       button1,
   input  logic       button2,
   output logic       tick,
   output logic       inc_tens,
   output logic       inc_units,
   output logic [1:0] field_sel,
   output logic [1:0] mode
);

   localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

   logic [2:0]  btn_vec;
   logic [2:0]  ev_vec;
   logic        set_ev;
   logic        b1_ev;
   logic        b2_ev;

   mode_t       mode_reg,      mode_next;
   logic [1:0]  field_reg,     field_next;
   logic [15:0] presc_reg,     presc_next;
   logic        tick_reg,      tick_next;
   logic        inc_tens_reg,  inc_tens_next;
   logic        inc_units_reg, inc_units_next;

   assign btn_vec = {button2, button1, setbutton};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_btn
         btn_edge u_btn_edge (
            .clk   (clk),
            .reset (reset),
            .btn   (btn_vec[gi]),
            .rise  (ev_vec[gi])
         );
      end
   endgenerate

   assign set_ev = ev_vec[0];
   assign b1_ev  = ev_vec[1];
   assign b2_ev  = ev_vec[2];

   always_ff @(posedge clk) begin
      if (!reset) begin
         mode_reg      <= MODE_RUN;
         field_reg     <= FIELD_NONE;
         presc_reg     <= 16'd0;
         tick_reg      <= 1'b0;
         inc_tens_reg  <= 1'b0;
         inc_units_reg <= 1'b0;
      end else begin
         mode_reg      <= mode_next;
         field_reg     <= field_next;
         presc_reg     <= presc_next;
         tick_reg      <= tick_next;
         inc_tens_reg  <= inc_tens_next;
         inc_units_reg <= inc_units_next;
      end
   end

   always_comb begin
      mode_next      = mode_reg;
      presc_next     = 16'd0;
      tick_next      = 1'b0;
      inc_tens_next  = 1'b0;
      inc_units_next = 1'b0;

      // A mode advance swallows any increment that lands on the same cycle.
      if (set_ev) begin
         unique case (mode_reg)
            MODE_RUN:      mode_next = MODE_SET_HOUR;
            MODE_SET_HOUR: mode_next = MODE_SET_MIN;
            MODE_SET_MIN:  mode_next = MODE_SET_SEC;
            MODE_SET_SEC:  mode_next = MODE_RUN;
         endcase
      end else if (mode_reg != MODE_RUN) begin
         inc_tens_next  = b1_ev;
         inc_units_next = b2_ev;
      end

      // Only count while staying in RUN, so leaving or entering RUN restarts at 0.
      if (mode_reg == MODE_RUN && mode_next == MODE_RUN) begin
         if (presc_reg == PRESC_MAX) begin
            presc_next = 16'd0;
            tick_next  = 1'b1;
         end else begin
            presc_next = presc_reg + 16'd1;
         end
      end

      field_next = field_of(mode_next);
   end

   assign tick      = tick_reg;
   assign inc_tens  = inc_tens_reg;
   assign inc_units = inc_units_reg;
   assign field_sel = field_reg;
   assign mode      = mode_reg;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl: directed scenarios plus random button traffic,
// all outputs compared every cycle against an event-queue reference model.
module tb_clock_mode_ctrl;

   localparam int TDIV = 10;

   logic       clk = 1'b0;
   logic       reset;
   logic       setbutton;
   logic       button1;
   logic       button2;
   logic       tick;
   logic       inc_tens;
   logic       inc_units;
   logic [1:0] field_sel;
   logic [1:0] mode;

   clock_mode_ctrl #(.TICK_DIV(TDIV)) dut (
      .clk       (clk),
      .reset     (reset),
      .setbutton (setbutton),
      .button1   (button1),
      .button2   (button2),
      .tick      (tick),
      .inc_tens  (inc_tens),
      .inc_units (inc_units),
      .field_sel (field_sel),
      .mode      (mode)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: each button rise is queued with a fixed two-edge delay.
   int edge_n = 0;
   int q_s[$];
   int q_b1[$];
   int q_b2[$];
   int prev_s = 0, prev_b1 = 0, prev_b2 = 0;
   int exp_mode = 0, exp_tick = 0, exp_tens = 0, exp_units = 0;
   int run_cycles = 0;

   int win_tick = 0, win_tens = 0, win_units = 0;

   task automatic check_val(input string tag, input int obs, input int exp_v);
      n_checks++;
      if (obs != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp_v, edge_n);
      end
   endtask

   task automatic model_edge();
      int ev_s, ev_1, ev_2;
      edge_n++;
      ev_s = 0; ev_1 = 0; ev_2 = 0;
      if (reset == 1'b0) begin
         q_s.delete(); q_b1.delete(); q_b2.delete();
         prev_s = 0; prev_b1 = 0; prev_b2 = 0;
         exp_mode = 0; exp_tick = 0; exp_tens = 0; exp_units = 0;
         run_cycles = 0;
      end else begin
         if (q_s.size() > 0 && q_s[0] == edge_n) begin ev_s = 1; void'(q_s.pop_front()); end
         if (q_b1.size() > 0 && q_b1[0] == edge_n) begin ev_1 = 1; void'(q_b1.pop_front()); end
         if (q_b2.size() > 0 && q_b2[0] == edge_n) begin ev_2 = 1; void'(q_b2.pop_front()); end
         if (setbutton && prev_s == 0) q_s.push_back(edge_n + 2);
         if (button1 && prev_b1 == 0) q_b1.push_back(edge_n + 2);
         if (button2 && prev_b2 == 0) q_b2.push_back(edge_n + 2);
         prev_s  = int'(setbutton);
         prev_b1 = int'(button1);
         prev_b2 = int'(button2);

         exp_tick = 0; exp_tens = 0; exp_units = 0;
         if (ev_s != 0) begin
            exp_mode   = (exp_mode + 1) % 4;
            run_cycles = 0;
         end else if (exp_mode != 0) begin
            exp_tens  = ev_1;
            exp_units = ev_2;
         end else begin
            run_cycles++;
            if (run_cycles % TDIV == 0) exp_tick = 1;
         end
      end
   endtask

   task automatic step(input logic r, input logic s, input logic b1, input logic b2);
      reset = r; setbutton = s; button1 = b1; button2 = b2;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_val("mode",      int'(mode),      exp_mode);
      check_val("field_sel", int'(field_sel), exp_mode);
      check_val("tick",      int'(tick),      exp_tick);
      check_val("inc_tens",  int'(inc_tens),  exp_tens);
      check_val("inc_units", int'(inc_units), exp_units);
      check_val("exclusive", int'(tick & (inc_tens | inc_units)), 0);
      win_tick  += int'(tick);
      win_tens  += int'(inc_tens);
      win_units += int'(inc_units);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic press();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      idle(4);
   endtask

   task automatic clear_win();
      win_tick = 0; win_tens = 0; win_units = 0;
   endtask

   initial begin
      logic rs, r1, r2, rr;
      reset = 1'b0; setbutton = 1'b0; button1 = 1'b0; button2 = 1'b0;

      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

      // Free run after reset: three ticks in 35 cycles.
      clear_win();
      idle(35);
      check_val("run_ticks", win_tick, 3);

      // Enter SET_HOUR with a long press, then digit presses.
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      idle(2);
      check_val("set_hour_mode", int'(mode), 1);
      check_val("set_hour_field", int'(field_sel), 1);
      clear_win();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
      idle(3);
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
         idle(2);
      end
      idle(2);
      check_val("hour_tens", win_tens, 1);
      check_val("hour_units", win_units, 2);
      check_val("hour_no_tick", win_tick, 0);

      // Walk back to RUN and let ticks resume.
      press(); check_val("to_min", int'(mode), 2);
      press(); check_val("to_sec", int'(mode), 3);
      press(); check_val("to_run", int'(mode), 0);
      idle(25);

      // Simultaneous digit events, then setbutton beating button2.
      press(); press();
      check_val("in_min", int'(mode), 2);
      clear_win();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
      idle(4);
      check_val("both_tens", win_tens, 1);
      check_val("both_units", win_units, 1);
      clear_win();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
      idle(4);
      check_val("set_wins_mode", int'(mode), 3);
      check_val("set_wins_units", win_units, 0);

      // Reset during SET_MIN with button2 held.
      press(); press(); press();
      check_val("min_again", int'(mode), 2);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
      check_val("rst_mode", int'(mode), 0);
      clear_win();
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
      check_val("post_rst_units", win_units, 0);
      check_val("post_rst_ticks", win_tick, 2);
      idle(3);

      // Long hold: one event in SET_HOUR, none in RUN.
      press();
      clear_win();
      for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
      idle(4);
      check_val("hold_set_units", win_units, 1);
      press(); press(); press();
      check_val("hold_back_run", int'(mode), 0);
      clear_win();
      for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
      idle(4);
      check_val("hold_run_units", win_units, 0);

      // Random traffic with occasional reset pulses.
      rs = 1'b0; r1 = 1'b0; r2 = 1'b0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 7) == 0) rs = ~rs;
         if ($urandom_range(0, 4) == 0) r1 = ~r1;
         if ($urandom_range(0, 4) == 0) r2 = ~r2;
         rr = ($urandom_range(0, 119) != 0);
         step(rr, rs, r1, r2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/clock_mode_ctrl.md
CLOCK_MODE_CTRL -- requirements
Module: clock_mode_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50, SHALL set the number of clk cycles per one-second tick; legal range 2..65535.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-low reset.
REQ-004 setbutton  input  1  SHALL be the raw mode-advance button, active-high.
REQ-005 button1  input  1  SHALL be the raw tens-digit increment button, active-high.
REQ-006 button2  input  1  SHALL be the raw units-digit increment button, active-high.
REQ-007 tick  output  1  SHALL be a one-cycle pulse commanding the time datapath to advance one second.
REQ-008 inc_tens  output  1  SHALL be a one-cycle pulse to increment the tens digit of the selected field.
REQ-009 inc_units  output  1  SHALL be a one-cycle pulse to increment the units digit of the selected field.
REQ-010 field_sel  output  2  SHALL select the field being set: 0 none, 1 hour, 2 min, 3 sec.
REQ-011 mode  output  2  SHALL report state: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC.

Function
REQ-012 Each button SHALL pass through a 2-flop synchroniser followed by a rising-edge detector; a held button SHALL yield exactly one event.
REQ-013 An event SHALL be produced at the first clock edge where the second sync flop is high and its delayed copy low; resulting output pulses SHALL be registered and appear on the following edge (total latency 3 edges from first high sample).
REQ-014 FSM SHALL advance on each setbutton event: RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
REQ-015 field_sel SHALL equal mode (0 in RUN, 1/2/3 in SET_HOUR/SET_MIN/SET_SEC), registered with mode.
REQ-016 In RUN a 16-bit prescaler SHALL count 0..TICK_DIV-1 and wrap; tick SHALL assert for one cycle on the cycle the count equals TICK_DIV-1.
REQ-017 In any SET state the prescaler SHALL hold at 0 and tick SHALL stay 0.
REQ-018 On transition SET_SEC -> RUN the prescaler SHALL restart at 0; first tick SHALL occur TICK_DIV cycles after mode reads RUN.
REQ-019 In SET states a button1 event SHALL pulse inc_tens and a button2 event SHALL pulse inc_units, each exactly one cycle.
REQ-020 In RUN button1/button2 events SHALL be discarded; inc_tens and inc_units SHALL stay 0.
REQ-021 Simultaneous button1 and button2 events SHALL both be issued in the same cycle.
REQ-022 A setbutton event coincident with a button1/button2 event SHALL win: state advances, increment events discarded.
REQ-023 tick, inc_tens, inc_units SHALL never assert in the same cycle.

Reset
REQ-024 While reset is low at a clk edge: mode=RUN, field_sel=0, tick=0, inc_tens=0, inc_units=0, prescaler=0, all sync/edge flops=0.
REQ-025 Reset asserted mid-SET SHALL abandon setting and return to RUN with no pending pulse emitted after release.
REQ-026 A button held high through reset release SHALL produce an event (edge flops cleared to 0).

Structure
REQ-027 Shared package clock_pkg SHALL hold the mode encoding, field_sel codes and TICK_DIV default.
REQ-028 Sub-module btn_edge (2-flop sync + rising-edge detector) SHALL be instantiated three times.

Verification (TICK_DIV=10)
REQ-029 Release reset, hold buttons low 35 cycles -> tick pulses exactly 3 times, spaced 10 cycles, mode=0.
REQ-030 setbutton 10 cycles, button1 once, button2 twice -> mode=1, field_sel=1, one inc_tens, two inc_units, no tick while in SET.
REQ-031 Three more setbutton presses -> mode 2, 3, then 0; first tick 10 cycles after mode=0.
REQ-032 button1 and button2 raised same cycle in SET_MIN -> inc_tens and inc_units high together for one cycle; setbutton with button2 same cycle -> mode advances, no inc_units.
REQ-033 Reset low for 5 cycles while in SET_MIN with button2 held -> mode=0, all outputs 0; after release inc_units stays 0 (RUN), tick resumes after 10 cycles.
REQ-034 button2 held 50 cycles in SET_HOUR -> exactly one inc_units pulse; in RUN -> none.
